// File: rtl/dmem_wbuf_responder.sv
// rtl/dmem_wbuf_responder.sv - data-memory responder with posted write buffer and read forwarding (option: DMEM_RANGE_CHECK_EN)
module dmem_wbuf_responder #(
    parameter int MEM_DEPTH  = 128,
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        wbuf_empty
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(WBUF_DEPTH);

    logic [15:0]   mem     [MEM_DEPTH];
    logic [AW-1:0] wb_idx  [WBUF_DEPTH];
    logic [15:0]   wb_data [WBUF_DEPTH];

    logic [PW-1:0] head, tail, slot;
    logic [CW-1:0] count;
    logic [AW-1:0] idx;
    logic          accept, push, pop, in_range, fwd_hit;
    logic [15:0]   fwd_data;

    assign idx        = req_addr[AW-1:0];
    assign req_ready  = (count != FULL_COUNT);
    assign wbuf_empty = (count == '0);
    assign accept     = req_valid && req_ready;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [16:0] ADDR_LIMIT = 17'(MEM_DEPTH);
    assign in_range = ({1'b0, req_addr} < ADDR_LIMIT);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[15:AW];
    assign in_range       = 1'b1;
`endif

    assign push = accept && req_write && in_range;
    // Drain only on cycles with no accepted request, so push and pop never coincide.
    assign pop  = !accept && (count != '0);

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            slot = head + PW'(i);
            if ((CW'(i) < count) && (wb_idx[slot] == idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_idx[tail]  <= idx;
            wb_data[tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            mem[wb_idx[head]] <= wb_data[head];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            addr_err   <= 1'b0;
`endif
        end else begin
            resp_valid <= accept && !req_write;
            if (accept && !req_write) begin
                resp_rdata <= !in_range ? 16'h0000 : (fwd_hit ? fwd_data : mem[idx]);
            end
`ifdef DMEM_RANGE_CHECK_EN
            addr_err <= accept && !in_range;
`endif
            if (push) begin
                tail  <= tail + 1'b1;
                count <= count + 1'b1;
            end else if (pop) begin
                head  <= head + 1'b1;
                count <= count - 1'b1;
            end
        end
    end

endmodule
